id_ex_skid_stage: RTL and testbench
===================================

# id_ex_skid_stage

Parametrised ID→EX pipeline stage register with a valid/ready handshake, a two-entry skid buffer, flush (bubble insertion) and a stall-cycle counter. It replaces the free-running ID/EX latch between decode and execute. Execute can back-pressure decode without losing an instruction, and a branch or hazard unit can squash in-flight entries. Field widths are parameters so the same block serves the EX/MEM and MEM/WB boundaries.

## Interface
- DATA_W, 32, width of each operand field
- RD_W, 5, destination register index width
- CTRL_W, 32, control word width
- ALUC_W, 5, ALU control width
- CNT_W, 16, stall counter width
- CLOCK  in  1  single clock, all state updates on posedge
- RESET_N  in  1  synchronous, active-low reset
- flush  in  1  squash all held entries this cycle
- in_valid  in  1  decode presents an instruction
- in_ready  out  1  stage accepts this cycle (registered)
- in_data_1, in_data_2  in  DATA_W  operands
- in_rd  in  RD_W  destination register
- in_ctrl  in  CTRL_W  control word
- in_alu_ctrl  in  ALUC_W  ALU control
- out_valid  out  1  execute-side entry valid
- out_ready  in  1  execute consumes this cycle
- out_data_1, out_data_2, out_rd, out_ctrl, out_alu_ctrl  out  widths as inputs  head entry payload
- occupancy  out  2  entries held (0..2)
- stall_cycles  out  CNT_W  saturating count of back-pressured cycles

## Operation
- Storage: two slots, main (drives outputs) and skid. Each slot is a valid bit plus a packed payload.
- States:
  - EMPTY: occupancy 0.
  - ONE: main valid.
  - TWO: main and skid valid.
- Handshakes: accept = in_valid & in_ready; consume = out_valid & out_ready.
- in_ready = !skid_valid. It is a registered value, with no combinational path from out_ready.
- EMPTY:
  - accept → main ← input, go to ONE.
- ONE:
  - consume & accept → main ← input, stay in ONE.
  - consume only → EMPTY.
  - accept only → skid ← input, go to TWO.
  - neither → hold.
- TWO:
  - consume → main ← skid, go to ONE. in_ready is 0, so no accept is possible.
  - no consume → hold.
- Ordering is strictly FIFO. An accepted entry is never dropped or duplicated except by flush.
- Flush:
  - Priority is below reset and above all handshake activity.
  - Clears both valid bits, forces out_ctrl to 0 and enters EMPTY.
  - An accept presented in the flush cycle is discarded.
  - Other payload fields retain their stale values.
- stall_cycles increments in every cycle where out_valid & !out_ready, including flush cycles.
  - Saturates at 2^CNT_W−1.
  - Cleared only by reset.
- Payload registers load only on accept or on a skid→main move. Outputs are stable while out_valid & !out_ready.

## Timing
- Reset (RESET_N=0 at posedge):
  - All outputs and payload are 0.
  - out_valid=0, in_ready=1, occupancy=0, stall_cycles=0.
- Reset asserted mid-transfer discards both entries. No partial update occurs.
- Latency: an instruction accepted at edge N appears on out_* after edge N, i.e. one cycle, when the stage was EMPTY or consumed in the same cycle.
- Throughput: one instruction per cycle with out_ready held high.
- Maximum buffered: 2 entries.
- in_ready deasserts the cycle after the second entry is captured. It reasserts the cycle after the consume that frees the skid slot.
- Flush and out_ready in the same cycle: flush wins. No consume is counted downstream.

## Structure
- Shared package `pipe_pkg`:
  - default width constants (DATA_W, RD_W, CTRL_W, ALUC_W).
  - the state enum {EMPTY, ONE, TWO}.
  - the bubble control constant CTRL_NOP = 0.
- Sub-module `pipe_slot`:
  - parametrised valid+payload register with load, clear and reset.
  - Instantiated twice, for main and skid.
- Payload packed as {data_1, data_2, rd, ctrl, alu_ctrl} inside the top.

## Test plan
- Reset: RESET_N low 2 cycles with random inputs → out_valid=0, in_ready=1, all out_* = 0, stall_cycles=0.
- Streaming: out_ready=1, issue 8 instructions with rd=1..8 back-to-back → out_rd = 1..8 on consecutive cycles, each one cycle after accept; occupancy never exceeds 1.
- Back-pressure: out_ready=0 while issuing rd=3, 4, 5 → 3 and 4 accepted; in_ready=0 from the third cycle so 5 is held off; occupancy=2. Then out_ready=1 → outputs 3, 4, 5 in order, no loss. stall_cycles equals the number of back-pressured cycles.
- Flush: with occupancy=2 and in_valid=1, pulse flush → next cycle out_valid=0, out_ctrl=0, occupancy=0; the offered entry is absent from the output stream.
- Saturation: CNT_W=4, hold out_valid=1, out_ready=0 for 20 cycles → stall_cycles stops at 15.
- Reset mid-operation: occupancy=2, assert RESET_N=0 for one cycle → state EMPTY, all outputs 0, in_ready=1 the following cycle.

Source files
------------

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared widths, stage state encoding and bubble control word
package pipe_pkg;

    localparam int DATA_W   = 32;
    localparam int RD_W     = 5;
    localparam int CTRL_W   = 32;
    localparam int ALUC_W   = 5;

    localparam int CTRL_NOP = 0;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

endpackage

// File: rtl/pipe_slot.sv
// rtl/pipe_slot.sv - one valid bit plus packed payload with load, clear and sync reset
module pipe_slot #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic         valid_i,
    input  logic [W-1:0] data_i,
    input  logic         clear_i,
    output logic         valid_o,
    output logic [W-1:0] data_o
);

    logic         valid_q;
    logic [W-1:0] data_q;

    // clear only drops the valid bit; payload keeps its last value
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (load_i) begin
            valid_q <= valid_i;
            data_q  <= data_i;
        end else if (clear_i) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/id_ex_skid_stage.sv
// rtl/id_ex_skid_stage.sv - ID/EX stage register with two-entry skid buffer, flush and stall counter
module id_ex_skid_stage #(
    parameter int DATA_W = pipe_pkg::DATA_W,
    parameter int RD_W   = pipe_pkg::RD_W,
    parameter int CTRL_W = pipe_pkg::CTRL_W,
    parameter int ALUC_W = pipe_pkg::ALUC_W,
    parameter int CNT_W  = 16
) (
    input  logic              CLOCK,
    input  logic              RESET_N,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data_1,
    input  logic [DATA_W-1:0] in_data_2,
    input  logic [RD_W-1:0]   in_rd,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [ALUC_W-1:0] in_alu_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data_1,
    output logic [DATA_W-1:0] out_data_2,
    output logic [RD_W-1:0]   out_rd,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [ALUC_W-1:0] out_alu_ctrl,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cycles
);

    import pipe_pkg::*;

    localparam int PAY_W = 2 * DATA_W + RD_W + CTRL_W + ALUC_W;

    state_t             state_q, state_d;
    logic [PAY_W-1:0]   in_pay, main_pay, skid_pay, squash_pay, main_din;
    logic               main_valid, skid_valid;
    logic               main_load, main_vin, main_clr, skid_load, skid_clr;
    logic               accept, consume;
    logic [CNT_W-1:0]   stall_q, stall_d;

    assign in_pay     = {in_data_1, in_data_2, in_rd, in_ctrl, in_alu_ctrl};
    // a flushed head keeps its stale operands but presents a bubble control word
    assign squash_pay = {main_pay[PAY_W-1:CTRL_W+ALUC_W], CTRL_W'(CTRL_NOP), main_pay[ALUC_W-1:0]};

    assign in_ready  = !skid_valid;
    assign out_valid = main_valid;
    assign accept    = in_valid & in_ready;
    assign consume   = main_valid & out_ready;

    always_ff @(posedge CLOCK) begin
        if (!RESET_N) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY:   if (accept) state_d = ONE;
                ONE: begin
                    if (consume && !accept)      state_d = EMPTY;
                    else if (!consume && accept) state_d = TWO;
                end
                TWO:     if (consume) state_d = ONE;
                default: state_d = EMPTY;
            endcase
        end
    end

    always_comb begin
        main_load = 1'b0;
        main_vin  = 1'b1;
        main_din  = in_pay;
        main_clr  = 1'b0;
        skid_load = 1'b0;
        skid_clr  = 1'b0;
        occupancy = 2'd0;
        case (state_q)
            ONE:     occupancy = 2'd1;
            TWO:     occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
        if (flush) begin
            main_load = 1'b1;
            main_vin  = 1'b0;
            main_din  = squash_pay;
            skid_clr  = 1'b1;
        end else begin
            case (state_q)
                EMPTY: main_load = accept;
                ONE: begin
                    if (consume && accept) main_load = 1'b1;
                    else if (consume)      main_clr  = 1'b1;
                    else if (accept)       skid_load = 1'b1;
                end
                TWO: begin
                    if (consume) begin
                        main_load = 1'b1;
                        main_din  = skid_pay;
                        skid_clr  = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    pipe_slot #(.W(PAY_W)) u_main (
        .clk     (CLOCK),
        .rst_n   (RESET_N),
        .load_i  (main_load),
        .valid_i (main_vin),
        .data_i  (main_din),
        .clear_i (main_clr),
        .valid_o (main_valid),
        .data_o  (main_pay)
    );

    pipe_slot #(.W(PAY_W)) u_skid (
        .clk     (CLOCK),
        .rst_n   (RESET_N),
        .load_i  (skid_load),
        .valid_i (1'b1),
        .data_i  (in_pay),
        .clear_i (skid_clr),
        .valid_o (skid_valid),
        .data_o  (skid_pay)
    );

    assign stall_d = (main_valid && !out_ready && stall_q != {CNT_W{1'b1}}) ? stall_q + 1'b1 : stall_q;

    always_ff @(posedge CLOCK) begin
        if (!RESET_N) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cycles = stall_q;
    assign {out_data_1, out_data_2, out_rd, out_ctrl, out_alu_ctrl} = main_pay;

endmodule

// File: tb/tb_id_ex_skid_stage.sv
// tb/tb_id_ex_skid_stage.sv - randomized and directed checks of id_ex_skid_stage against a queue model
module tb_id_ex_skid_stage;

    typedef struct packed {
        logic [31:0] d1;
        logic [31:0] d2;
        logic [4:0]  rd;
        logic [31:0] ctrl;
        logic [4:0]  alu;
    } pay_t;

    logic        CLOCK = 1'b0;
    logic        RESET_N, flush, in_valid, out_ready;
    logic        in_ready, out_valid;
    logic [31:0] in_data_1, in_data_2, in_ctrl;
    logic [4:0]  in_rd, in_alu_ctrl;
    logic [31:0] out_data_1, out_data_2, out_ctrl;
    logic [4:0]  out_rd, out_alu_ctrl;
    logic [1:0]  occupancy;
    logic [3:0]  stall_cycles;

    int total = 0;
    int bad   = 0;

    pay_t q[$];
    pay_t shown;
    int   m_stall;

    always #5 CLOCK = ~CLOCK;

    id_ex_skid_stage #(.CNT_W(4)) dut (
        .CLOCK        (CLOCK),
        .RESET_N      (RESET_N),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data_1    (in_data_1),
        .in_data_2    (in_data_2),
        .in_rd        (in_rd),
        .in_ctrl      (in_ctrl),
        .in_alu_ctrl  (in_alu_ctrl),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data_1   (out_data_1),
        .out_data_2   (out_data_2),
        .out_rd       (out_rd),
        .out_ctrl     (out_ctrl),
        .out_alu_ctrl (out_alu_ctrl),
        .occupancy    (occupancy),
        .stall_cycles (stall_cycles)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic rand_payload();
        in_data_1   = $urandom;
        in_data_2   = $urandom;
        in_ctrl     = $urandom;
        in_alu_ctrl = 5'($urandom);
        in_rd       = 5'($urandom);
    endtask

    // FIFO semantics: up to two entries; when empty the outputs keep the last head shown
    task automatic model_step();
        pay_t cur;
        bit   acc, con;
        cur = '{d1: in_data_1, d2: in_data_2, rd: in_rd, ctrl: in_ctrl, alu: in_alu_ctrl};
        if (!RESET_N) begin
            q.delete();
            shown   = '0;
            m_stall = 0;
        end else begin
            if (q.size() > 0 && !out_ready && m_stall < 15) m_stall++;
            if (flush) begin
                if (q.size() > 0) shown = q[0];
                shown.ctrl = '0;
                q.delete();
            end else begin
                acc = in_valid && (q.size() < 2);
                con = (q.size() > 0) && out_ready;
                if (con) shown = q.pop_front();
                if (acc) q.push_back(cur);
            end
        end
    endtask

    task automatic check_model();
        pay_t e;
        e = (q.size() > 0) ? q[0] : shown;
        chk("out_valid",    64'(out_valid),    64'(q.size() > 0));
        chk("in_ready",     64'(in_ready),     64'(q.size() < 2));
        chk("occupancy",    64'(occupancy),    64'(q.size()));
        chk("stall_cycles", 64'(stall_cycles), 64'(m_stall));
        chk("out_data_1",   64'(out_data_1),   64'(e.d1));
        chk("out_data_2",   64'(out_data_2),   64'(e.d2));
        chk("out_rd",       64'(out_rd),       64'(e.rd));
        chk("out_ctrl",     64'(out_ctrl),     64'(e.ctrl));
        chk("out_alu_ctrl", 64'(out_alu_ctrl), 64'(e.alu));
    endtask

    task automatic step();
        @(posedge CLOCK);
        model_step();
        @(negedge CLOCK);
        check_model();
    endtask

    initial begin
        shown   = '0;
        m_stall = 0;
        RESET_N = 1'b0;
        flush   = $urandom_range(0, 1);
        in_valid  = $urandom_range(0, 1);
        out_ready = $urandom_range(0, 1);
        rand_payload();
        step();
        rand_payload();
        step();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready",  64'(in_ready),  64'd1);
        chk("rst_occ",       64'(occupancy), 64'd0);
        chk("rst_stall",     64'(stall_cycles), 64'd0);
        chk("rst_payload",   64'(out_data_1 | out_data_2 | out_ctrl | 32'(out_rd) | 32'(out_alu_ctrl)), 64'd0);

        // streaming
        RESET_N = 1'b1; flush = 1'b0; out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            rand_payload();
            in_valid = 1'b1;
            in_rd    = 5'(i);
            step();
            chk("stream_rd",  64'(out_rd), 64'(i));
            chk("stream_occ", 64'(occupancy), 64'd1);
        end
        in_valid = 1'b0;
        step();
        chk("stream_drain_occ", 64'(occupancy), 64'd0);

        // back-pressure
        out_ready = 1'b0; in_valid = 1'b1;
        rand_payload(); in_rd = 5'd3; step();
        rand_payload(); in_rd = 5'd4; step();
        chk("bp_occ2",  64'(occupancy), 64'd2);
        chk("bp_ready", 64'(in_ready), 64'd0);
        rand_payload(); in_rd = 5'd5; step();
        step();
        chk("bp_head",  64'(out_rd), 64'd3);
        chk("bp_stall", 64'(stall_cycles), 64'd3);
        out_ready = 1'b1;
        step();
        chk("bp_out4",  64'(out_rd), 64'd4);
        step();
        chk("bp_out5",  64'(out_rd), 64'd5);
        in_valid = 1'b0;
        step();
        chk("bp_empty", 64'(occupancy), 64'd0);

        // flush with two held and one offered
        out_ready = 1'b0; in_valid = 1'b1;
        rand_payload(); in_rd = 5'd10; step();
        rand_payload(); in_rd = 5'd11; step();
        rand_payload(); in_rd = 5'd12; flush = 1'b1; step();
        chk("fl_valid", 64'(out_valid), 64'd0);
        chk("fl_ctrl",  64'(out_ctrl), 64'd0);
        chk("fl_occ",   64'(occupancy), 64'd0);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        step();
        step();
        chk("fl_absent", 64'(out_valid), 64'd0);

        // saturation
        RESET_N = 1'b0; step();
        RESET_N = 1'b1; in_valid = 1'b1; rand_payload(); step();
        in_valid = 1'b0; out_ready = 1'b0;
        for (int i = 0; i < 20; i++) step();
        chk("sat_stall", 64'(stall_cycles), 64'd15);

        // reset while two entries held
        in_valid = 1'b1; rand_payload(); step();
        chk("mid_occ2", 64'(occupancy), 64'd2);
        RESET_N = 1'b0; rand_payload(); step();
        RESET_N = 1'b1; in_valid = 1'b0;
        chk("mid_valid", 64'(out_valid), 64'd0);
        chk("mid_ready", 64'(in_ready), 64'd1);
        chk("mid_stall", 64'(stall_cycles), 64'd0);
        chk("mid_pay",   64'(out_data_1 | out_data_2 | out_ctrl | 32'(out_rd) | 32'(out_alu_ctrl)), 64'd0);
        step();

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            RESET_N   = ($urandom_range(0, 149) != 0);
            flush     = ($urandom_range(0, 19) == 0);
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            rand_payload();
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
